// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
//  - ALU sub-operation encodings seen by this stage (loads, stores, NOP, OR).
//  - Register-file bus widths.
//  - FSM state encoding for the data-RAM handshake.
//  - Helper functions that classify an aluop as a load or a store.
package mem_stage_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;
  localparam int ALUOP_W    = 8;

  localparam logic [REG_W-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  function automatic logic is_load(input logic [ALUOP_W-1:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [ALUOP_W-1:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane logic for the memory stage (purely combinational).
// Big-endian: addr[1:0]=00 addresses bits 31:24.
// Ports:
//  aluop_i    load/store sub-operation
//  addr_lo_i  low two address bits
//  sdata_i    store data (rt)
//  rdata_i    load data word from the RAM
//  sel_o      byte-lane enables
//  wdata_o    lane-replicated store data (0 for non-stores)
//  ldata_o    sign/zero-extended load result
module mem_lane
  import mem_stage_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [REG_W-1:0]   sdata_i,
  input  logic [REG_W-1:0]   rdata_i,
  output logic [3:0]         sel_o,
  output logic [REG_W-1:0]   wdata_o,
  output logic [REG_W-1:0]   ldata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = 8'h00;
    case (addr_lo_i)
      2'b00:   rbyte = rdata_i[31:24];
      2'b01:   rbyte = rdata_i[23:16];
      2'b10:   rbyte = rdata_i[15:8];
      default: rbyte = rdata_i[7:0];
    endcase
    rhalf = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    sel_o   = 4'b0000;
    wdata_o = ZERO_WORD;
    ldata_o = ZERO_WORD;
    case (aluop_i)
      EXE_LB_OP: begin
        sel_o   = 4'b1000 >> addr_lo_i;
        ldata_o = {{24{rbyte[7]}}, rbyte};
      end
      EXE_LBU_OP: begin
        sel_o   = 4'b1000 >> addr_lo_i;
        ldata_o = {24'h0, rbyte};
      end
      EXE_LH_OP: begin
        sel_o   = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        ldata_o = {{16{rhalf[15]}}, rhalf};
      end
      EXE_LHU_OP: begin
        sel_o   = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        ldata_o = {16'h0, rhalf};
      end
      EXE_LW_OP: begin
        sel_o   = 4'b1111;
        ldata_o = rdata_i;
      end
      EXE_SB_OP: begin
        sel_o   = 4'b1000 >> addr_lo_i;
        wdata_o = {4{sdata_i[7:0]}};
      end
      EXE_SH_OP: begin
        sel_o   = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wdata_o = {2{sdata_i[15:0]}};
      end
      EXE_SW_OP: begin
        sel_o   = 4'b1111;
        wdata_o = sdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: latches execute results, performs loads/stores over a
// req/ack data-RAM port, stalls the pipeline while an access is outstanding and
// delivers the write-back triple (wd/wreg/wdata) to the MEM/WB register.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned half/word detection).
// Ports:
//  clk, rst           clock (rising edge), asynchronous active-low reset
//  stall_i, flush_i   latch hold / latch bubble (flush wins)
//  ex_*_i             execute results: wd, wreg, wdata, aluop, maddr, sdata
//  mem_req_o/we_o/sel_o/addr_o/data_o, mem_ack_i/data_i   data-RAM port
//  wd_o, wreg_o, wdata_o   write-back triple
//  stallreq_o         stall request while an access is outstanding
//  excp_align_o       misaligned access flag (0 without MEM_ALIGN_CHECK_EN)
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter bit POSTED_STORE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  ex_wreg_i,
  input  logic [REG_W-1:0]      ex_wdata_i,
  input  logic [ALUOP_W-1:0]    ex_aluop_i,
  input  logic [ADDR_W-1:0]     ex_maddr_i,
  input  logic [REG_W-1:0]      ex_sdata_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_sel_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [REG_W-1:0]      mem_data_o,
  input  logic                  mem_ack_i,
  input  logic [REG_W-1:0]      mem_data_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [REG_W-1:0]      wdata_o,
  output logic                  stallreq_o,
  output logic                  excp_align_o
);

  // Input latch
  logic [REG_ADDR_W-1:0] wd_q, wd_d;
  logic                  wreg_q, wreg_d;
  logic [REG_W-1:0]      wdata_q, wdata_d;
  logic [ALUOP_W-1:0]    aluop_q, aluop_d;
  logic [ADDR_W-1:0]     maddr_q, maddr_d;
  logic [REG_W-1:0]      sdata_q, sdata_d;

  // Handshake state
  mem_state_e        state_q, state_d;
  logic              kill_q, kill_d;
  logic              posted_q, posted_d;
  logic [REG_W-1:0]  rdata_q, rdata_d;

  // Copy of the access taken at issue so a flush of the latch cannot disturb the bus
  logic [ALUOP_W-1:0] acc_op_q;
  logic [ADDR_W-1:0]  acc_addr_q;
  logic [REG_W-1:0]   acc_sdata_q;

  logic               issue, posted_issue, in_req, misalign, is_mem, drop;
  logic [ALUOP_W-1:0] cur_op;
  logic [ADDR_W-1:0]  cur_addr;
  logic [REG_W-1:0]   cur_sdata;
  logic [3:0]         lane_sel;
  logic [REG_W-1:0]   lane_wdata, lane_ldata;

  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    aluop_d = aluop_q;
    maddr_d = maddr_q;
    sdata_d = sdata_q;
    if (flush_i) begin
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = ZERO_WORD;
      aluop_d = EXE_NOP_OP;
      maddr_d = '0;
      sdata_d = ZERO_WORD;
    end else if (!stall_i) begin
      wd_d    = ex_wd_i;
      wreg_d  = ex_wreg_i;
      wdata_d = ex_wdata_i;
      aluop_d = ex_aluop_i;
      maddr_d = ex_maddr_i;
      sdata_d = ex_sdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      wdata_q  <= ZERO_WORD;
      aluop_q  <= EXE_NOP_OP;
      maddr_q  <= '0;
      sdata_q  <= ZERO_WORD;
      state_q  <= MEM_IDLE;
      kill_q   <= 1'b0;
      posted_q <= 1'b0;
      rdata_q  <= ZERO_WORD;
    end else begin
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      aluop_q  <= aluop_d;
      maddr_q  <= maddr_d;
      sdata_q  <= sdata_d;
      state_q  <= state_d;
      kill_q   <= kill_d;
      posted_q <= posted_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      acc_op_q    <= aluop_q;
      acc_addr_q  <= maddr_q;
      acc_sdata_q <= sdata_q;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (aluop_q)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misalign = maddr_q[0];
      EXE_LW_OP, EXE_SW_OP:             misalign = |maddr_q[1:0];
      default: ;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign in_req    = (state_q == MEM_REQ);
  assign is_mem    = is_load(aluop_q) | is_store(aluop_q);
  assign cur_op    = in_req ? acc_op_q : aluop_q;
  assign cur_addr  = in_req ? acc_addr_q : maddr_q;
  assign cur_sdata = in_req ? acc_sdata_q : sdata_q;

  mem_lane u_lane (
    .aluop_i   (cur_op),
    .addr_lo_i (cur_addr[1:0]),
    .sdata_i   (cur_sdata),
    .rdata_i   (mem_data_i),
    .sel_o     (lane_sel),
    .wdata_o   (lane_wdata),
    .ldata_o   (lane_ldata)
  );

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    posted_d     = 1'b0;
    rdata_d      = rdata_q;
    issue        = 1'b0;
    posted_issue = 1'b0;
    drop         = kill_q | flush_i;
    case (state_q)
      MEM_IDLE: begin
        if (is_mem && !misalign) begin
          if (POSTED_STORE && is_store(aluop_q)) begin
            // Fire once; if the store stays latched (stall) it must not repeat.
            posted_issue = !posted_q;
            posted_d     = stall_i && !flush_i;
          end else begin
            issue = 1'b1;
            // ack may arrive in the same cycle the request rises
            if (mem_ack_i) begin
              state_d = flush_i ? MEM_IDLE : MEM_DONE;
              if (!flush_i && is_load(aluop_q)) rdata_d = lane_ldata;
            end else begin
              state_d = MEM_REQ;
              kill_d  = flush_i;
            end
          end
        end
      end
      MEM_REQ: begin
        if (mem_ack_i) begin
          // A flushed access still finishes on the bus, but its result is dropped.
          state_d = drop ? MEM_IDLE : MEM_DONE;
          kill_d  = 1'b0;
          if (!drop && is_load(acc_op_q)) rdata_d = lane_ldata;
        end else begin
          kill_d = drop;
        end
      end
      MEM_DONE: begin
        if (!stall_i) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign mem_req_o  = issue | posted_issue | in_req;
  assign stallreq_o = issue | in_req;
  assign mem_we_o   = mem_req_o & is_store(cur_op);
  assign mem_sel_o  = mem_req_o ? lane_sel : 4'b0000;
  assign mem_addr_o = mem_req_o ? {cur_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_data_o = mem_req_o ? lane_wdata : ZERO_WORD;

  assign excp_align_o = misalign;
  assign wd_o         = wd_q;
  assign wdata_o      = (state_q == MEM_DONE) ? rdata_q : wdata_q;
  // Loads write back only from DONE; stores and misaligned ops never write back.
  assign wreg_o = wreg_q & ~in_req & ~misalign & ~is_store(aluop_q)
                & ~(is_load(aluop_q) & (state_q != MEM_DONE));

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_ext, flush_i;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic [31:0] ex_wdata_i;
  logic [7:0]  ex_aluop_i;
  logic [31:0] ex_maddr_i, ex_sdata_i;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  logic        mem_req_o, mem_we_o, wreg_o, stallreq_o, excp_align_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_addr_o, mem_data_o, wdata_o;
  logic [4:0]  wd_o;

  logic        req_p, we_p, wreg_p, stallreq_p, excp_p;
  logic [3:0]  sel_p;
  logic [31:0] addr_p, data_p, wdata_p;
  logic [4:0]  wd_p;

  logic stall_m, stall_pp;
  assign stall_m  = stall_ext | stallreq_o;
  assign stall_pp = stall_ext | stallreq_p;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32), .POSTED_STORE(1'b0)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_m), .flush_i(flush_i),
    .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
    .ex_aluop_i(ex_aluop_i), .ex_maddr_i(ex_maddr_i), .ex_sdata_i(ex_sdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o), .excp_align_o(excp_align_o)
  );

  mem_stage #(.ADDR_W(32), .POSTED_STORE(1'b1)) dut_p (
    .clk(clk), .rst(rst), .stall_i(stall_pp), .flush_i(flush_i),
    .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
    .ex_aluop_i(ex_aluop_i), .ex_maddr_i(ex_maddr_i), .ex_sdata_i(ex_sdata_i),
    .mem_req_o(req_p), .mem_we_o(we_p), .mem_sel_o(sel_p),
    .mem_addr_o(addr_p), .mem_data_o(data_p),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .wd_o(wd_p), .wreg_o(wreg_p), .wdata_o(wdata_p),
    .stallreq_o(stallreq_p), .excp_align_o(excp_p)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [4:0]  wd;
    logic [31:0] wdata;
  } wb_t;
  wb_t exp_q[$];

  // Write-back monitor: a result is accepted when wreg_o is high and the stage is not stalled.
  always @(negedge clk) begin
    wb_t e;
    if (rst && wreg_o && !stall_m) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected: got wd=%0d wdata=%h, required no write-back", wd_o, wdata_o);
      end else begin
        e = exp_q.pop_front();
        if (wd_o !== e.wd || wdata_o !== e.wdata) begin
          n_bad++;
          $display("FAIL wb_data: got wd=%0d wdata=%h, required wd=%0d wdata=%h",
                   wd_o, wdata_o, e.wd, e.wdata);
        end
      end
    end
  end

  int   req_rises = 0;
  logic req_prev  = 1'b0;
  always @(negedge clk) begin
    if (mem_req_o && !req_prev) req_rises++;
    req_prev = mem_req_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd);
    ex_wd_i = wd; ex_wreg_i = wreg; ex_wdata_i = wdata;
    ex_aluop_i = op; ex_maddr_i = addr; ex_sdata_i = sd;
  endtask

  task automatic set_nop();
    set_ex(5'd0, 1'b0, 32'h0, EXE_NOP_OP, 32'h0, 32'h0);
  endtask

  // Latch one load/store, answer with ack after 'delay' cycles, check the bus and stall length.
  task automatic run_access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [31:0] rdata, input int delay,
                            input logic [3:0] esel, input logic [31:0] eaddr,
                            input logic [31:0] emdata, input logic st);
    int stalls;
    bit done;
    stalls = 0;
    done   = 1'b0;
    set_ex(5'd9, 1'b1, 32'h0BAD_0000, op, addr, sd);
    tick();
    set_nop();
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      mem_ack_i  = (cyc == delay);
      mem_data_i = (cyc == delay) ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      if (cyc == 0) begin
        chk({tag, "_req"}, mem_req_o, 1);
        chk({tag, "_we"}, mem_we_o, st);
        chk({tag, "_sel"}, mem_sel_o, esel);
        chk({tag, "_addr"}, mem_addr_o, eaddr);
        chk({tag, "_mdata"}, mem_data_o, emdata);
        chk({tag, "_wreg_busy"}, wreg_o, 0);
        chk({tag, "_posted_stall"}, stallreq_p, !st);
      end
      if (cyc == 1 && st) chk({tag, "_posted_one_pulse"}, req_p, 0);
      if (stallreq_o) stalls++;
      if (cyc == delay) done = 1'b1;
      tick();
    end
    mem_ack_i = 1'b0;
    chk({tag, "_stall_cycles"}, stalls, delay + 1);
    @(negedge clk);
    chk({tag, "_done_req"}, mem_req_o, 0);
    chk({tag, "_done_stall"}, stallreq_o, 0);
    if (st) chk({tag, "_store_wreg"}, wreg_o, 0);
    tick();
  endtask

  initial begin
    int r0;
    rst = 1'b0; stall_ext = 1'b0; flush_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    set_ex(5'd7, 1'b1, 32'h1234_5678, EXE_OR_OP, 32'h10, 32'h0);

    // Reset: outputs stay zero even with live execute inputs
    repeat (2) tick();
    @(negedge clk);
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_stall", stallreq_o, 0);
    tick();
    set_nop();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_wreg", wreg_o, 0);
    chk("post_rst_req", mem_req_o, 0);
    tick();

    // Non-memory pass-through
    set_ex(5'd5, 1'b1, 32'h0000_F0F0, EXE_OR_OP, 32'h0, 32'h0);
    exp_q.push_back('{wd: 5'd5, wdata: 32'h0000_F0F0});
    tick();
    set_nop();
    @(negedge clk);
    chk("or_wd", wd_o, 5);
    chk("or_wreg", wreg_o, 1);
    chk("or_wdata", wdata_o, 32'h0000_F0F0);
    chk("or_stall", stallreq_o, 0);
    chk("or_req", mem_req_o, 0);
    tick();

    // Loads with sign / zero extension
    exp_q.push_back('{wd: 5'd9, wdata: 32'hFFFF_FF83});
    run_access("lb", EXE_LB_OP, 32'h102, 32'h0, 32'h1122_83FF, 3, 4'b0010, 32'h100, 32'h0, 1'b0);
    exp_q.push_back('{wd: 5'd9, wdata: 32'h0000_0083});
    run_access("lbu", EXE_LBU_OP, 32'h102, 32'h0, 32'h1122_83FF, 3, 4'b0010, 32'h100, 32'h0, 1'b0);
    exp_q.push_back('{wd: 5'd9, wdata: 32'h0000_8001});
    run_access("lhu", EXE_LHU_OP, 32'h100, 32'h0, 32'h8001_0000, 0, 4'b1100, 32'h100, 32'h0, 1'b0);

    // Stores with lane replication
    run_access("sh", EXE_SH_OP, 32'h200, 32'hAAAA_1234, 32'h0, 1, 4'b1100, 32'h200, 32'h1234_1234, 1'b1);
    run_access("sb", EXE_SB_OP, 32'h203, 32'h0000_00A5, 32'h0, 2, 4'b0001, 32'h200, 32'hA5A5_A5A5, 1'b1);
    run_access("sw", EXE_SW_OP, 32'h204, 32'hCAFE_BABE, 32'h0, 1, 4'b1111, 32'h204, 32'hCAFE_BABE, 1'b1);

    // Flush while in REQ: access completes, result dropped
    set_ex(5'd12, 1'b1, 32'h0, EXE_LW_OP, 32'h300, 32'h0);
    tick();
    set_nop();
    @(negedge clk);
    chk("fl_req0", mem_req_o, 1);
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    chk("fl_req1", mem_req_o, 1);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    chk("fl_req2", mem_req_o, 1);
    chk("fl_addr2", mem_addr_o, 32'h300);
    tick();
    mem_ack_i = 1'b1; mem_data_i = 32'h5555_5555;
    @(negedge clk);
    chk("fl_req3", mem_req_o, 1);
    tick();
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("fl_after_req", mem_req_o, 0);
    chk("fl_after_stall", stallreq_o, 0);
    chk("fl_after_wreg", wreg_o, 0);
    chk("fl_after_wdata", wdata_o, 32'h0);
    tick();

    // Asynchronous reset in REQ
    set_ex(5'd13, 1'b1, 32'h0, EXE_LW_OP, 32'h400, 32'h0);
    tick();
    set_nop();
    @(negedge clk);
    chk("ar_req0", mem_req_o, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("ar_req_drop", mem_req_o, 0);
    chk("ar_stall_drop", stallreq_o, 0);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("ar_after_req", mem_req_o, 0);
    tick();

    // DONE held by stall: stable data, no re-issue
    set_ex(5'd9, 1'b1, 32'h0BAD_0000, EXE_LH_OP, 32'h202, 32'h0);
    exp_q.push_back('{wd: 5'd9, wdata: 32'hFFFF_8344});
    tick();
    set_nop();
    r0 = req_rises;
    mem_ack_i = 1'b1; mem_data_i = 32'h1122_8344;
    @(negedge clk);
    chk("dn_stall0", stallreq_o, 1);
    tick();
    mem_ack_i = 1'b0;
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dn_wdata_stable", wdata_o, 32'hFFFF_8344);
      chk("dn_no_req", mem_req_o, 0);
      tick();
    end
    stall_ext = 1'b0;
    @(negedge clk);
    chk("dn_release_stall", stallreq_o, 0);
    tick();
    @(negedge clk);
    chk("dn_idle_req", mem_req_o, 0);
    tick();
    chk("dn_req_pulses", req_rises - r0, 1);

    // Misaligned word load
`ifdef MEM_ALIGN_CHECK_EN
    set_ex(5'd9, 1'b1, 32'h0, EXE_LW_OP, 32'h101, 32'h0);
    tick();
    set_nop();
    @(negedge clk);
    chk("al_excp", excp_align_o, 1);
    chk("al_req", mem_req_o, 0);
    chk("al_wreg", wreg_o, 0);
    chk("al_stall", stallreq_o, 0);
    tick();
    @(negedge clk);
    chk("al_excp_clear", excp_align_o, 0);
    tick();
`else
    exp_q.push_back('{wd: 5'd9, wdata: 32'hCAFE_F00D});
    run_access("lw_unal", EXE_LW_OP, 32'h101, 32'h0, 32'hCAFE_F00D, 1, 4'b1111, 32'h100, 32'h0, 1'b0);
    chk("lw_unal_excp", excp_align_o, 0);
`endif

    repeat (2) tick();
    chk("wb_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
